// File: rtl/id_ex_stage_if.sv
// ============================================================================
// id_ex_stage_if: ID-side inputs, forwarding sources and ALU-side outputs of
// the ID/EX stage. Rev 1.0
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              hold;
  logic              flush;
  logic              id_valid;
  logic [4:0]        id_ALUCode;
  logic              id_ALUSrcA;
  logic              id_ALUSrcB;
  logic              id_uses_rt;
  logic              id_RegWrite;
  logic              id_MemRead;
  logic              id_MemWrite;
  logic              id_MemtoReg;
  logic              id_RegDst;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm32;
  logic [4:0]        id_shamt;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              mem_RegWrite;
  logic [REG_AW-1:0] mem_WriteReg;
  logic [DATA_W-1:0] mem_Result;
  logic              wb_RegWrite;
  logic [REG_AW-1:0] wb_WriteReg;
  logic [DATA_W-1:0] wb_Data;
  logic              load_use_stall;
  logic              ex_valid;
  logic [4:0]        ex_ALUCode;
  logic [DATA_W-1:0] ex_A;
  logic [DATA_W-1:0] ex_B;
  logic [DATA_W-1:0] ex_StoreData;
  logic [REG_AW-1:0] ex_WriteReg;
  logic              ex_RegWrite;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              ex_MemtoReg;

  modport slave (
    input  hold, flush, id_valid, id_ALUCode, id_ALUSrcA, id_ALUSrcB, id_uses_rt,
           id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_RegDst,
           id_rs_data, id_rt_data, id_imm32, id_shamt, id_rs, id_rt, id_rd,
           mem_RegWrite, mem_WriteReg, mem_Result, wb_RegWrite, wb_WriteReg, wb_Data,
    output load_use_stall, ex_valid, ex_ALUCode, ex_A, ex_B, ex_StoreData,
           ex_WriteReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg
  );

  modport master (
    output hold, flush, id_valid, id_ALUCode, id_ALUSrcA, id_ALUSrcB, id_uses_rt,
           id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_RegDst,
           id_rs_data, id_rt_data, id_imm32, id_shamt, id_rs, id_rt, id_rd,
           mem_RegWrite, mem_WriteReg, mem_Result, wb_RegWrite, wb_WriteReg, wb_Data,
    input  load_use_stall, ex_valid, ex_ALUCode, ex_A, ex_B, ex_StoreData,
           ex_WriteReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage: ID/EX pipeline register, EX operand forwarding and load-use
// hazard detection for the 5-stage MIPS pipeline. Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  logic              r_valid;
  logic [4:0]        r_alucode;
  logic              r_srca;
  logic              r_srcb;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_memtoreg;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_wreg;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_shamt;

  logic              w_stall;
  logic              w_bubble;
  logic              w_wb_hits_rs;
  logic              w_wb_hits_rt;
  logic [DATA_W-1:0] w_cap_rs_data;
  logic [DATA_W-1:0] w_cap_rt_data;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // A load in EX whose target is read by the ID instruction cannot be forwarded in time.
  assign w_stall = r_valid & r_memread & (r_rt != '0) & bus.id_valid &
                   ((r_rt == bus.id_rs) | (bus.id_uses_rt & (r_rt == bus.id_rt)));
  assign w_bubble = bus.flush | w_stall;

  // The register file is written in the same cycle it is read, so take WB data directly.
  assign w_wb_hits_rs  = bus.wb_RegWrite & (bus.wb_WriteReg != '0) & (bus.wb_WriteReg == bus.id_rs);
  assign w_wb_hits_rt  = bus.wb_RegWrite & (bus.wb_WriteReg != '0) & (bus.wb_WriteReg == bus.id_rt);
  assign w_cap_rs_data = w_wb_hits_rs ? bus.wb_Data : bus.id_rs_data;
  assign w_cap_rt_data = w_wb_hits_rt ? bus.wb_Data : bus.id_rt_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_alucode  <= 5'b00000;
      r_srca     <= 1'b0;
      r_srcb     <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_wreg     <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_shamt    <= 5'b00000;
    end else if (!bus.hold) begin
      r_srca    <= bus.id_ALUSrcA;
      r_srcb    <= bus.id_ALUSrcB;
      r_rs      <= bus.id_rs;
      r_rt      <= bus.id_rt;
      r_wreg    <= bus.id_RegDst ? bus.id_rd : bus.id_rt;
      r_rs_data <= w_cap_rs_data;
      r_rt_data <= w_cap_rt_data;
      r_imm     <= bus.id_imm32;
      r_shamt   <= bus.id_shamt;
      if (w_bubble) begin
        r_valid    <= 1'b0;
        r_alucode  <= 5'b00000;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_memtoreg <= 1'b0;
      end else begin
        r_valid    <= bus.id_valid;
        r_alucode  <= bus.id_ALUCode;
        r_regwrite <= bus.id_RegWrite;
        r_memread  <= bus.id_MemRead;
        r_memwrite <= bus.id_MemWrite;
        r_memtoreg <= bus.id_MemtoReg;
      end
    end
  end

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
  assign w_fwd_rs = (bus.mem_RegWrite & (bus.mem_WriteReg != '0) & (bus.mem_WriteReg == r_rs)) ? bus.mem_Result :
                    (bus.wb_RegWrite  & (bus.wb_WriteReg  != '0) & (bus.wb_WriteReg  == r_rs)) ? bus.wb_Data :
                    r_rs_data;
  assign w_fwd_rt = (bus.mem_RegWrite & (bus.mem_WriteReg != '0) & (bus.mem_WriteReg == r_rt)) ? bus.mem_Result :
                    (bus.wb_RegWrite  & (bus.wb_WriteReg  != '0) & (bus.wb_WriteReg  == r_rt)) ? bus.wb_Data :
                    r_rt_data;

  assign bus.load_use_stall = w_stall;
  assign bus.ex_valid       = r_valid;
  assign bus.ex_ALUCode     = r_alucode;
  assign bus.ex_A           = r_srca ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_rs;
  assign bus.ex_B           = r_srcb ? r_imm : w_fwd_rt;
  assign bus.ex_StoreData   = w_fwd_rt;
  assign bus.ex_WriteReg    = r_wreg;
  assign bus.ex_RegWrite    = r_regwrite;
  assign bus.ex_MemRead     = r_memread;
  assign bus.ex_MemWrite    = r_memwrite;
  assign bus.ex_MemtoReg    = r_memtoreg;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage: directed and random checks of id_ex_stage against a
// behavioural model of the EX slot. Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model of the instruction sitting in EX; 'known' is false after a bubble,
  // when the data fields are don't-care.
  typedef struct {
    logic        valid;
    logic [4:0]  alucode;
    logic        srca, srcb, regwrite, memread, memwrite, memtoreg;
    logic [4:0]  rs, rt, wreg;
    logic [31:0] rsv, rtv, imm;
    logic [4:0]  shamt;
    bit          known;
  } slot_t;

  slot_t m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 0) return v;
    if (bus.mem_RegWrite && bus.mem_WriteReg == r) return bus.mem_Result;
    if (bus.wb_RegWrite && bus.wb_WriteReg == r) return bus.wb_Data;
    return v;
  endfunction

  function automatic logic [31:0] bypass(input logic [4:0] r, input logic [31:0] v);
    if (r != 0 && bus.wb_RegWrite && bus.wb_WriteReg == r) return bus.wb_Data;
    return v;
  endfunction

  function automatic logic exp_stall();
    if (!(m.valid && m.memread && m.rt != 0 && bus.id_valid)) return 1'b0;
    return (m.rt == bus.id_rs) || (bus.id_uses_rt && m.rt == bus.id_rt);
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m.known = 1'b1;
  endtask

  task automatic compare_model();
    chk("stall", bus.load_use_stall, exp_stall());
    chk("valid", bus.ex_valid, m.valid);
    chk("alucode", bus.ex_ALUCode, m.alucode);
    chk("regwrite", bus.ex_RegWrite, m.regwrite);
    chk("memread", bus.ex_MemRead, m.memread);
    chk("memwrite", bus.ex_MemWrite, m.memwrite);
    chk("memtoreg", bus.ex_MemtoReg, m.memtoreg);
    if (m.known) begin
      chk("A", bus.ex_A, m.srca ? {27'b0, m.shamt} : fwd(m.rs, m.rsv));
      chk("B", bus.ex_B, m.srcb ? m.imm : fwd(m.rt, m.rtv));
      chk("storedata", bus.ex_StoreData, fwd(m.rt, m.rtv));
      chk("writereg", bus.ex_WriteReg, m.wreg);
    end
  endtask

  task automatic update_model();
    logic st;
    st = exp_stall();
    if (reset) begin
      model_reset();
    end else if (!bus.hold) begin
      if (bus.flush || st) begin
        m.valid = 0; m.alucode = 0; m.regwrite = 0; m.memread = 0;
        m.memwrite = 0; m.memtoreg = 0; m.known = 0;
      end else begin
        m.valid = bus.id_valid;       m.alucode = bus.id_ALUCode;
        m.srca = bus.id_ALUSrcA;      m.srcb = bus.id_ALUSrcB;
        m.regwrite = bus.id_RegWrite; m.memread = bus.id_MemRead;
        m.memwrite = bus.id_MemWrite; m.memtoreg = bus.id_MemtoReg;
        m.rs = bus.id_rs;             m.rt = bus.id_rt;
        m.wreg = bus.id_RegDst ? bus.id_rd : bus.id_rt;
        m.rsv = bypass(bus.id_rs, bus.id_rs_data);
        m.rtv = bypass(bus.id_rt, bus.id_rt_data);
        m.imm = bus.id_imm32;         m.shamt = bus.id_shamt;
        m.known = 1;
      end
    end
  endtask

  // Check at the falling edge, advance the model, then move inputs just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    bus.mem_RegWrite = 0; bus.mem_WriteReg = 0; bus.mem_Result = 0;
    bus.wb_RegWrite  = 0; bus.wb_WriteReg  = 0; bus.wb_Data    = 0;
  endtask

  task automatic rand_id();
    bus.id_valid    = ($urandom_range(0, 3) != 0);
    bus.id_ALUCode  = 5'($urandom);
    bus.id_ALUSrcA  = 1'($urandom);
    bus.id_ALUSrcB  = 1'($urandom);
    bus.id_uses_rt  = 1'($urandom);
    bus.id_RegWrite = 1'($urandom);
    bus.id_MemRead  = 1'($urandom);
    bus.id_MemWrite = 1'($urandom);
    bus.id_MemtoReg = 1'($urandom);
    bus.id_RegDst   = 1'($urandom);
    bus.id_rs_data  = $urandom;
    bus.id_rt_data  = $urandom;
    bus.id_imm32    = $urandom;
    bus.id_shamt    = 5'($urandom);
    bus.id_rs       = 5'($urandom_range(0, 7));
    bus.id_rt       = 5'($urandom_range(0, 7));
    bus.id_rd       = 5'($urandom_range(0, 7));
  endtask

  task automatic load_instr(input logic [4:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [4:0] shamt,
                            input logic srca, input logic srcb, input logic uses_rt,
                            input logic regwrite, input logic memread, input logic memwrite,
                            input logic memtoreg, input logic regdst);
    bus.id_valid = 1;          bus.id_ALUCode = alu;
    bus.id_rs = rs;            bus.id_rt = rt;            bus.id_rd = rd;
    bus.id_rs_data = rsd;      bus.id_rt_data = rtd;      bus.id_imm32 = imm;
    bus.id_shamt = shamt;      bus.id_ALUSrcA = srca;     bus.id_ALUSrcB = srcb;
    bus.id_uses_rt = uses_rt;  bus.id_RegWrite = regwrite;
    bus.id_MemRead = memread;  bus.id_MemWrite = memwrite;
    bus.id_MemtoReg = memtoreg; bus.id_RegDst = regdst;
  endtask

  task automatic load_lw4();
    load_instr(5'd0, 5'd1, 5'd4, 5'd0, 32'h100, 32'h0, 32'h8, 5'd0, 0, 1, 0, 1, 1, 0, 1, 0);
  endtask

  task automatic load_add_r4();
    load_instr(5'd2, 5'd4, 5'd4, 5'd5, 32'h0BAD, 32'h0BAD, 32'h0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1; bus.hold = 0; bus.flush = 0;
    clear_fwd();
    rand_id();
    bus.id_valid = 1;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held with a valid instruction offered in ID
    for (int i = 0; i < 3; i++) begin
      rand_id();
      bus.id_valid = 1;
      cycle();
    end
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_regwrite", bus.ex_RegWrite, 0);
    chk("rst_alucode", bus.ex_ALUCode, 0);
    chk("rst_stall", bus.load_use_stall, 0);
    reset = 0;

    // add $3,$1,$2 then a reader of $3
    load_instr(5'd2, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 1);
    cycle();
    load_instr(5'd2, 5'd3, 5'd0, 5'd6, 32'h33, 32'h0, 32'h0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 1);
    #1;
    chk("add_A", bus.ex_A, 32'h5);
    chk("add_B", bus.ex_B, 32'h7);
    chk("add_wreg", bus.ex_WriteReg, 32'd3);
    cycle();
    bus.mem_RegWrite = 1; bus.mem_WriteReg = 3; bus.mem_Result = 32'h1234;
    #1 chk("fwd_mem_A", bus.ex_A, 32'h1234);
    bus.wb_RegWrite = 1; bus.wb_WriteReg = 3; bus.wb_Data = 32'hBBBB; bus.mem_Result = 32'hAAAA;
    #1 chk("fwd_prio_A", bus.ex_A, 32'hAAAA);
    bus.mem_RegWrite = 0;
    #1 chk("fwd_wb_A", bus.ex_A, 32'hBBBB);
    bus.mem_RegWrite = 1; bus.mem_WriteReg = 0; bus.wb_WriteReg = 0;
    #1 chk("fwd_r0_A", bus.ex_A, 32'h33);
    load_instr(5'd2, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 1);
    bus.mem_Result = 32'hDEAD; bus.wb_Data = 32'hBEEF;
    cycle();
    #1 chk("no_fwd_r0", bus.ex_A, 32'h0);

    // lw $4 then add $5,$4,$4: one stall, one bubble, then WB-forwarded operands
    clear_fwd();
    load_lw4();
    cycle();
    load_add_r4();
    #1 chk("lu_stall", bus.load_use_stall, 1);
    cycle();
    bus.mem_RegWrite = 1; bus.mem_WriteReg = 4; bus.mem_Result = 32'h108;
    #1 chk("lu_bubble", bus.ex_valid, 0);
    chk("lu_stall_drop", bus.load_use_stall, 0);
    cycle();
    bus.mem_RegWrite = 0;
    bus.wb_RegWrite = 1; bus.wb_WriteReg = 4; bus.wb_Data = 32'h4444;
    #1 chk("lu_add_valid", bus.ex_valid, 1);
    chk("lu_add_A", bus.ex_A, 32'h4444);
    chk("lu_add_B", bus.ex_B, 32'h4444);
    cycle();

    // Flush together with stall
    clear_fwd();
    load_lw4();
    cycle();
    load_add_r4();
    bus.flush = 1;
    #1 chk("fl_stall", bus.load_use_stall, 1);
    cycle();
    bus.flush = 0;
    #1 chk("fl_bubble", bus.ex_valid, 0);
    chk("fl_stall_drop", bus.load_use_stall, 0);

    // Hold for four cycles while ID churns
    load_instr(5'd3, 5'd1, 5'd2, 5'd7, 32'h1111, 32'h2222, 32'h0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 1);
    cycle();
    bus.hold = 1;
    for (int i = 0; i < 4; i++) begin
      rand_id();
      cycle();
      chk("hold_A", bus.ex_A, 32'h1111);
    end
    chk("hold_B", bus.ex_B, 32'h2222);
    chk("hold_wreg", bus.ex_WriteReg, 32'd7);
    chk("hold_alucode", bus.ex_ALUCode, 32'd3);
    chk("hold_valid", bus.ex_valid, 1);
    bus.hold = 0;

    // Hold during a stall, then reset mid-hold
    load_lw4();
    cycle();
    load_add_r4();
    bus.hold = 1;
    #1 chk("hs_stall0", bus.load_use_stall, 1);
    cycle();
    chk("hs_stall1", bus.load_use_stall, 1);
    chk("hs_memread", bus.ex_MemRead, 1);
    cycle();
    chk("hs_stall2", bus.load_use_stall, 1);
    reset = 1;
    cycle();
    reset = 0; bus.hold = 0;
    #1 chk("hs_rst_valid", bus.ex_valid, 0);
    chk("hs_rst_stall", bus.load_use_stall, 0);

    // sll with shamt=4, rt=1
    load_instr(5'd4, 5'd0, 5'd1, 5'd8, 32'h0, 32'h1, 32'h0, 5'd4, 1, 0, 1, 1, 0, 0, 0, 1);
    cycle();
    #1 chk("sll_A", bus.ex_A, 32'h4);
    chk("sll_B", bus.ex_B, 32'h1);

    // sw whose rt is forwarded from EX/MEM
    load_instr(5'd0, 5'd2, 5'd6, 5'd0, 32'h200, 32'h66, 32'h10, 5'd0, 0, 1, 1, 0, 0, 1, 0, 0);
    cycle();
    bus.mem_RegWrite = 1; bus.mem_WriteReg = 6; bus.mem_Result = 32'h600D;
    #1 chk("sw_store", bus.ex_StoreData, 32'h600D);
    chk("sw_B", bus.ex_B, 32'h10);
    clear_fwd();

    // Capture bypass from MEM/WB into the ID/EX register
    load_instr(5'd1, 5'd9, 5'd0, 5'd10, 32'h99, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 1);
    bus.wb_RegWrite = 1; bus.wb_WriteReg = 9; bus.wb_Data = 32'h9999;
    cycle();
    clear_fwd();
    #1 chk("bypass_A", bus.ex_A, 32'h9999);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 31) == 0);
      bus.hold  = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      rand_id();
      bus.mem_RegWrite = 1'($urandom); bus.mem_WriteReg = 5'($urandom_range(0, 7));
      bus.mem_Result   = $urandom;
      bus.wb_RegWrite  = 1'($urandom); bus.wb_WriteReg  = 5'($urandom_range(0, 7));
      bus.wb_Data      = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
